// File: rtl/pll_lock_reset_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_reset_sequencer_if
// Description : PLL lock / domain reset bundle between the reset sequencer
//               (slave) and the PLL plus clock domains around it (master).
// Revision    : 1.0 - initial release
// ============================================================================
interface pll_lock_reset_sequencer_if #(
    parameter int QUANTITY_OF_CLK_DOMAINS = 1
);
    logic                               i_pll_locked;
    logic                               i_clear_sticky;
    logic                               o_pll_reset;
    logic [QUANTITY_OF_CLK_DOMAINS-1:0] o_domain_reset_n;
    logic                               o_all_released;
    logic                               o_lock_lost_sticky;
    logic [7:0]                         o_retry_count;

    // Sequencer side
    modport slave (
        input  i_pll_locked,
        input  i_clear_sticky,
        output o_pll_reset,
        output o_domain_reset_n,
        output o_all_released,
        output o_lock_lost_sticky,
        output o_retry_count
    );

    // PLL / environment side
    modport master (
        output i_pll_locked,
        output i_clear_sticky,
        input  o_pll_reset,
        input  o_domain_reset_n,
        input  o_all_released,
        input  o_lock_lost_sticky,
        input  o_retry_count
    );
endinterface
`default_nettype wire

// File: rtl/pll_lock_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_reset_sequencer
// Description : Holds the PLL in reset, waits for a stable synchronised lock,
//               then releases the per-domain resets in order (bit 0 first).
//               Any lock loss after release began tears everything down and
//               restarts from the PLL reset.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_reset_sequencer #(
    parameter int QUANTITY_OF_CLK_DOMAINS = 1,
    parameter int PLL_RESET_CYCLES        = 16,
    parameter int LOCK_TIMEOUT            = 1_000_000,
    parameter int STABLE_CYCLES           = 1024,
    parameter int RELEASE_GAP             = 8,
    parameter int SYNC_STAGES             = 2
) (
    input  logic                        i_clk,
    input  logic                        i_async_reset_n,
    pll_lock_reset_sequencer_if.slave   bus
);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Count at which the last domain is released, measured from RELEASE entry
    localparam int RELEASE_SPAN = (QUANTITY_OF_CLK_DOMAINS - 1) * RELEASE_GAP;
    localparam int MAX_COUNT    = max_of(max_of(PLL_RESET_CYCLES, LOCK_TIMEOUT),
                                         max_of(STABLE_CYCLES, RELEASE_SPAN + 1));
    localparam int CNT_W        = $clog2(MAX_COUNT) + 1;

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_SPAN);

    localparam logic [2:0] ST_PLL_RST     = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK   = 3'd1;
    localparam logic [2:0] ST_LOCK_STABLE = 3'd2;
    localparam logic [2:0] ST_RELEASE     = 3'd3;
    localparam logic [2:0] ST_RUN         = 3'd4;

    logic [SYNC_STAGES-1:0]             lock_sync;
    logic                               locked;
    logic [2:0]                         state;
    logic [2:0]                         state_next;
    logic [CNT_W-1:0]                   count;
    logic                               lock_loss;
    logic                               timeout_hit;
    logic                               pll_reset;
    logic [QUANTITY_OF_CLK_DOMAINS-1:0] domain_reset_n;
    logic                               all_released;
    logic                               lock_lost_sticky;
    logic [7:0]                         retry_count;

    // Only the last sync stage is trusted; the raw lock is never used directly
    assign locked = lock_sync[SYNC_STAGES-1];

    // Synchronise the raw PLL lock into the quartz clock domain
    always_ff @(posedge i_clk or negedge i_async_reset_n) begin
        if (!i_async_reset_n) begin
            lock_sync <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], bus.i_pll_locked};
        end
    end

    // Next-state decode; lock loss only counts once release has begun
    always_comb begin
        state_next  = state;
        lock_loss   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_PLL_RST: begin
                if (count == PLL_RST_LAST) begin
                    state_next = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked) begin
                    state_next = ST_LOCK_STABLE;
                end else if (count == TIMEOUT_LAST) begin
                    state_next  = ST_PLL_RST;
                    timeout_hit = 1'b1;
                end
            end
            ST_LOCK_STABLE: begin
                if (!locked) begin
                    state_next = ST_WAIT_LOCK;
                end else if (count == STABLE_LAST) begin
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!locked) begin
                    state_next = ST_PLL_RST;
                    lock_loss  = 1'b1;
                end else if (count == RELEASE_LAST) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!locked) begin
                    state_next = ST_PLL_RST;
                    lock_loss  = 1'b1;
                end
            end
            default: begin
                state_next = ST_PLL_RST;
            end
        endcase
    end

    // State register and the shared counter, cleared on every state change
    always_ff @(posedge i_clk or negedge i_async_reset_n) begin
        if (!i_async_reset_n) begin
            state <= ST_PLL_RST;
            count <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                count <= '0;
            end else if (state != ST_RUN) begin
                count <= count + 1'b1;
            end
        end
    end

    // Registered decode of the next state keeps PLL reset and RUN flag glitch-free
    always_ff @(posedge i_clk or negedge i_async_reset_n) begin
        if (!i_async_reset_n) begin
            pll_reset    <= 1'b1;
            all_released <= 1'b0;
        end else begin
            pll_reset    <= (state_next == ST_PLL_RST);
            all_released <= (state_next == ST_RUN);
        end
    end

    // Domain resets: bit 0 on RELEASE entry, bit k RELEASE_GAP*k later; all drop on loss
    always_ff @(posedge i_clk or negedge i_async_reset_n) begin
        if (!i_async_reset_n) begin
            domain_reset_n <= '0;
        end else if (state_next == ST_PLL_RST) begin
            domain_reset_n <= '0;
        end else begin
            if (state == ST_LOCK_STABLE && state_next == ST_RELEASE) begin
                domain_reset_n[0] <= 1'b1;
            end
            for (int k = 1; k < QUANTITY_OF_CLK_DOMAINS; k++) begin
                if (state == ST_RELEASE && count == CNT_W'(k * RELEASE_GAP - 1)) begin
                    domain_reset_n[k] <= 1'b1;
                end
            end
        end
    end

    // Sticky lock-lost flag; a simultaneous loss beats the clear pulse
    always_ff @(posedge i_clk or negedge i_async_reset_n) begin
        if (!i_async_reset_n) begin
            lock_lost_sticky <= 1'b0;
        end else if (lock_loss) begin
            lock_lost_sticky <= 1'b1;
        end else if (bus.i_clear_sticky) begin
            lock_lost_sticky <= 1'b0;
        end
    end

    // Saturating count of lock timeouts
    always_ff @(posedge i_clk or negedge i_async_reset_n) begin
        if (!i_async_reset_n) begin
            retry_count <= 8'd0;
        end else if (timeout_hit && retry_count != 8'hFF) begin
            retry_count <= retry_count + 8'd1;
        end
    end

    assign bus.o_pll_reset        = pll_reset;
    assign bus.o_domain_reset_n   = domain_reset_n;
    assign bus.o_all_released     = all_released;
    assign bus.o_lock_lost_sticky = lock_lost_sticky;
    assign bus.o_retry_count      = retry_count;

endmodule
`default_nettype wire
